riscv_decode_stage: RTL and testbench

Registered RV32/RV64 decode front-end between fetch and register-read. Each accepted instruction word is classified into instruction_type_e and imm_type_e. The block produces a sign-extended XLEN immediate and an illegal flag. A valid/ready pipeline register plus a skid buffer give full throughput under backpressure, and a flush input kills everything in flight.

---
 rtl/riscv_pkg.sv | 51 +++++
 rtl/riscv_imm_gen.sv | 36 +++
 rtl/riscv_decode_stage.sv | 175 +++++++++++++++++
 tb/tb_riscv_decode_stage.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V decode types: instruction/immediate classes, major opcodes, sign-extension helper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package riscv_pkg;

    // UNKNOWN_TYPE is encoded as zero so a cleared entry reads back as "no instruction".
    typedef enum logic [2:0] {
        UNKNOWN_TYPE = 3'd0,
        R_TYPE       = 3'd1,
        I_TYPE       = 3'd2,
        S_TYPE       = 3'd3,
        B_TYPE       = 3'd4,
        U_TYPE       = 3'd5,
        J_TYPE       = 3'd6
    } instruction_type_e;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_type_e;

    localparam logic [6:0] OPC_OP         = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM     = 7'b0010011;
    localparam logic [6:0] OPC_LOAD       = 7'b0000011;
    localparam logic [6:0] OPC_STORE      = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH     = 7'b1100011;
    localparam logic [6:0] OPC_LUI        = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC      = 7'b0010111;
    localparam logic [6:0] OPC_JAL        = 7'b1101111;
    localparam logic [6:0] OPC_JALR       = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM     = 7'b1110011;
    localparam logic [6:0] OPC_FENCE      = 7'b0001111;
    localparam logic [6:0] OPC_OP_32      = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM_32  = 7'b0011011;

    // Sign-extend a field whose sign bit sits at position msb; everything above
    // msb is replaced by copies of that bit.
    function automatic logic [31:0] sign_extend(input logic [31:0] val, input logic [4:0] msb);
        logic [31:0] res;
        res = '0;
        for (int i = 0; i < 32; i++) begin
            res[i] = (5'(i) <= msb) ? val[i] : val[msb];
        end
        return res;
    endfunction

endpackage

// File: rtl/riscv_imm_gen.sv
// Immediate generator: reassembles the RISC-V immediate scatter and sign-extends to XLEN.
// Latency: purely combinational.
// Backpressure: none (no state).
// Ports: instr_i - instruction bits [31:7] (opcode never carries immediate bits),
//        imm_type_i - immediate format, imm_o - XLEN sign-extended immediate (0 for IMM_NONE).
module riscv_imm_gen
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     instr_i,
    input  imm_type_e       imm_type_i,
    output logic [XLEN-1:0] imm_o
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (imm_type_i)
            IMM_I: imm32 = sign_extend({20'b0, instr_i[31:20]}, 5'd11);
            IMM_S: imm32 = sign_extend({20'b0, instr_i[31:25], instr_i[11:7]}, 5'd11);
            IMM_B: imm32 = sign_extend({19'b0, instr_i[31], instr_i[7], instr_i[30:25],
                                        instr_i[11:8], 1'b0}, 5'd12);
            IMM_U: imm32 = {instr_i[31:12], 12'b0};
            IMM_J: imm32 = sign_extend({11'b0, instr_i[31], instr_i[19:12], instr_i[20],
                                        instr_i[30:21], 1'b0}, 5'd20);
            default: imm32 = '0;
        endcase
    end

    // Every format has its sign at instr[31], so widening the 32-bit value as
    // signed gives the correct RV64 immediate.
    assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/riscv_decode_stage.sv
// Registered RV32/RV64 decode stage: classifies the instruction, builds its immediate, flags illegals.
// Latency: 1 cycle from accept to out_valid; flush clears all held entries the next cycle.
// Backpressure: main + skid entry (SKID_EN=1) gives full throughput, in_ready is a pure flop output.
// Ports: clk/rst_n (async active-low), flush_i; in_valid/in_ready/in_instr/in_pc from fetch;
//        out_valid/out_ready/out_instr/out_pc/out_itype/out_imm_type/out_imm/out_illegal to register-read.
module riscv_decode_stage
    import riscv_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SKID_EN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [XLEN-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [XLEN-1:0]   out_pc,
    output instruction_type_e out_itype,
    output imm_type_e         out_imm_type,
    output logic [XLEN-1:0]   out_imm,
    output logic              out_illegal
);

    typedef struct packed {
        logic [31:0]       instr;
        logic [XLEN-1:0]   pc;
        instruction_type_e itype;
        imm_type_e         imm_type;
        logic [XLEN-1:0]   imm;
        logic              illegal;
    } entry_t;

    instruction_type_e dec_itype;
    imm_type_e         dec_imm_type;
    logic [XLEN-1:0]   dec_imm;
    entry_t            dec_entry;

    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   main_valid_q, main_valid_d;
    logic   skid_valid_q, skid_valid_d;

    logic accept;
    logic pop;

    // ---------------- decode ----------------
    always_comb begin
        dec_itype    = UNKNOWN_TYPE;
        dec_imm_type = IMM_NONE;
        case (in_instr[6:0])
            OPC_OP: begin
                dec_itype = R_TYPE;
            end
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM, OPC_FENCE: begin
                dec_itype    = I_TYPE;
                dec_imm_type = IMM_I;
            end
            OPC_STORE: begin
                dec_itype    = S_TYPE;
                dec_imm_type = IMM_S;
            end
            OPC_BRANCH: begin
                dec_itype    = B_TYPE;
                dec_imm_type = IMM_B;
            end
            OPC_LUI, OPC_AUIPC: begin
                dec_itype    = U_TYPE;
                dec_imm_type = IMM_U;
            end
            OPC_JAL: begin
                dec_itype    = J_TYPE;
                dec_imm_type = IMM_J;
            end
            OPC_OP_32: begin
                if (XLEN == 64) dec_itype = R_TYPE;
            end
            OPC_OP_IMM_32: begin
                if (XLEN == 64) begin
                    dec_itype    = I_TYPE;
                    dec_imm_type = IMM_I;
                end
            end
            default: begin
                dec_itype    = UNKNOWN_TYPE;
                dec_imm_type = IMM_NONE;
            end
        endcase
    end

    riscv_imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .instr_i    (in_instr[31:7]),
        .imm_type_i (dec_imm_type),
        .imm_o      (dec_imm)
    );

    always_comb begin
        dec_entry          = '0;
        dec_entry.instr    = in_instr;
        dec_entry.pc       = in_pc;
        dec_entry.itype    = dec_itype;
        dec_entry.imm_type = dec_imm_type;
        dec_entry.imm      = dec_imm;
        dec_entry.illegal  = (dec_itype == UNKNOWN_TYPE) || (in_instr[1:0] != 2'b11);
    end

    // ---------------- handshake ----------------
    // With the skid entry, in_ready depends on state only, so out_ready never
    // reaches fetch combinationally; the skid absorbs the one word in flight.
    assign in_ready = (SKID_EN != 0) ? !skid_valid_q : (!main_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign pop      = main_valid_q && out_ready;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush_i) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (pop) begin
            if (skid_valid_q) begin
                // in_ready is low while the skid is full, so no accept can collide here.
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d       = dec_entry;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (main_valid_q) begin
                if (SKID_EN != 0) begin
                    skid_d       = dec_entry;
                    skid_valid_d = 1'b1;
                end
            end else begin
                main_d       = dec_entry;
                main_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
        end
    end

    assign out_valid    = main_valid_q;
    assign out_instr    = main_q.instr;
    assign out_pc       = main_q.pc;
    assign out_itype    = main_q.itype;
    assign out_imm_type = main_q.imm_type;
    assign out_imm      = main_q.imm;
    assign out_illegal  = main_q.illegal;

endmodule

// File: tb/tb_riscv_decode_stage.sv
module tb_riscv_decode_stage;
    import riscv_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              flush_i;
    logic              in_valid;
    logic [31:0]       in_instr;
    logic [31:0]       in_pc;
    logic [63:0]       in_pc64;

    logic              in_ready, out_valid, out_illegal;
    logic [31:0]       out_instr, out_pc, out_imm;
    instruction_type_e out_itype;
    imm_type_e         out_imm_type;

    logic              in_ready64, out_valid64, out_illegal64;
    logic [31:0]       out_instr64;
    logic [63:0]       out_pc64, out_imm64;
    instruction_type_e out_itype64;
    imm_type_e         out_imm_type64;

    logic              out_ready;

    int checks   = 0;
    int failures = 0;

    riscv_decode_stage #(.XLEN(32), .SKID_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .out_itype(out_itype), .out_imm_type(out_imm_type), .out_imm(out_imm),
        .out_illegal(out_illegal)
    );

    riscv_decode_stage #(.XLEN(64), .SKID_EN(1)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr), .in_pc(in_pc64),
        .out_valid(out_valid64), .out_ready(out_ready), .out_instr(out_instr64), .out_pc(out_pc64),
        .out_itype(out_itype64), .out_imm_type(out_imm_type64), .out_imm(out_imm64),
        .out_illegal(out_illegal64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        in_valid = v;
        in_instr = instr;
        in_pc    = pc;
        in_pc64  = {32'b0, pc};
    endtask

    initial begin
        rst_n     = 1'b0;
        flush_i   = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        #3;
        // ---- reset state ----
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_itype", out_itype, UNKNOWN_TYPE);
        check("rst_imm_type", out_imm_type, IMM_NONE);
        check("rst_illegal", out_illegal, 0);
        check("rst_imm", out_imm, 0);
        check("rst_instr", out_instr, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", in_ready, 1);

        // ---- single addi x1,x0,-1 ----
        out_ready = 1'b1;
        drive(1'b1, 32'hFFF00093, 32'h100);
        tick();
        check("addi_valid", out_valid, 1);
        check("addi_itype", out_itype, I_TYPE);
        check("addi_imm_type", out_imm_type, IMM_I);
        check("addi_imm", out_imm, 64'hFFFFFFFF);
        check("addi_illegal", out_illegal, 0);
        check("addi_pc", out_pc, 64'h100);

        // ---- back-to-back stream sw / beq / lui ----
        drive(1'b1, 32'h00112623, 32'h104);
        tick();
        check("sw_instr", out_instr, 64'h00112623);
        check("sw_itype", out_itype, S_TYPE);
        check("sw_imm", out_imm, 64'd12);
        drive(1'b1, 32'hFE000EE3, 32'h108);
        tick();
        check("beq_valid", out_valid, 1);
        check("beq_itype", out_itype, B_TYPE);
        check("beq_imm_type", out_imm_type, IMM_B);
        check("beq_imm", out_imm, 64'hFFFFFFFC);
        drive(1'b1, 32'h123450B7, 32'h10C);
        tick();
        check("lui_itype", out_itype, U_TYPE);
        check("lui_imm", out_imm, 64'h12345000);
        check("lui_pc", out_pc, 64'h10C);
        drive(1'b1, 32'h004000EF, 32'h110);
        tick();
        check("jal_itype", out_itype, J_TYPE);
        check("jal_imm", out_imm, 64'd4);
        drive(1'b0, 32'h0, 32'h0);
        tick();
        check("stream_drain", out_valid, 0);

        // ---- stall: 3 offers while out_ready=0 ----
        out_ready = 1'b0;
        drive(1'b1, 32'hFFF00093, 32'h200);
        tick();
        check("stall_a_valid", out_valid, 1);
        check("stall_a_in_ready", in_ready, 1);
        drive(1'b1, 32'h00112623, 32'h204);
        tick();
        check("stall_b_in_ready", in_ready, 0);
        check("stall_b_hold", out_instr, 64'hFFF00093);
        drive(1'b1, 32'h123450B7, 32'h208);
        tick();
        check("stall_c_in_ready", in_ready, 0);
        check("stall_c_hold_instr", out_instr, 64'hFFF00093);
        check("stall_c_hold_pc", out_pc, 64'h200);
        out_ready = 1'b1;
        tick();
        check("rel_b_instr", out_instr, 64'h00112623);
        check("rel_b_pc", out_pc, 64'h204);
        check("rel_in_ready", in_ready, 1);
        tick();
        check("rel_c_instr", out_instr, 64'h123450B7);
        check("rel_c_pc", out_pc, 64'h208);
        drive(1'b0, 32'h0, 32'h0);
        tick();
        check("rel_drain", out_valid, 0);

        // ---- flush with main and skid full ----
        out_ready = 1'b0;
        drive(1'b1, 32'hFFF00093, 32'h300);
        tick();
        drive(1'b1, 32'h00112623, 32'h304);
        tick();
        check("fl_full_in_ready", in_ready, 0);
        flush_i = 1'b1;
        drive(1'b1, 32'h123450B7, 32'h308);
        tick();
        check("fl_out_valid", out_valid, 0);
        check("fl_in_ready", in_ready, 1);
        flush_i   = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'h0, 32'h0);
        tick();
        check("fl_nothing_emitted", out_valid, 0);

        // ---- flush discards a same-cycle accept ----
        out_ready = 1'b0;
        drive(1'b1, 32'hFFF00093, 32'h400);
        tick();
        flush_i = 1'b1;
        drive(1'b1, 32'h00112623, 32'h404);
        tick();
        check("fl2_out_valid", out_valid, 0);
        flush_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        tick();
        check("fl2_discarded", out_valid, 0);

        // ---- RV64-only opcodes and illegal words ----
        out_ready = 1'b1;
        drive(1'b1, 32'hFFF0809B, 32'h500);
        tick();
        check("addiw32_itype", out_itype, UNKNOWN_TYPE);
        check("addiw32_illegal", out_illegal, 1);
        check("addiw32_imm", out_imm, 0);
        check("addiw64_itype", out_itype64, I_TYPE);
        check("addiw64_imm", out_imm64, 64'hFFFFFFFFFFFFFFFF);
        check("addiw64_illegal", out_illegal64, 0);
        drive(1'b1, 32'h002080BB, 32'h504);
        tick();
        check("addw64_itype", out_itype64, R_TYPE);
        check("addw32_illegal", out_illegal, 1);
        drive(1'b1, 32'h00000000, 32'h508);
        tick();
        check("zero_illegal", out_illegal, 1);
        check("zero_itype", out_itype, UNKNOWN_TYPE);
        check("zero_valid", out_valid, 1);
        drive(1'b0, 32'h0, 32'h0);
        tick();

        // ---- async reset mid-stall ----
        out_ready = 1'b0;
        drive(1'b1, 32'hFFF00093, 32'h600);
        tick();
        drive(1'b1, 32'h00112623, 32'h604);
        tick();
        check("ar_full", in_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_out_valid", out_valid, 0);
        check("ar_in_ready", in_ready, 1);
        drive(1'b0, 32'h0, 32'h0);
        #3;
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        check("ar_no_stale", out_valid, 0);
        tick();
        check("ar_no_stale2", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
